// File: rtl/mux_scan.sv
// mux_scan: M-channel N-bit registered mux with manual select and self-timed one-hot scan (optional blanking via MUX_SCAN_BLANK_EN)
module mux_scan #(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [M*N-1:0]       d,
    input  logic                 mode,
    input  logic [$clog2(M)-1:0] sel,
    input  logic [M-1:0]         en,
    output logic [N-1:0]         y,
    output logic [$clog2(M)-1:0] ch,
    output logic [M-1:0]         strobe,
    output logic                 tick
);
    localparam int SW = $clog2(M);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] ch_n, nxt;
    logic [M-1:0]  strobe_n;
    logic [N-1:0]  y_n;
    logic          tick_n, run, wrap, found;

    // next enabled channel above ch, wrapping; lands on ch itself if it is the only one enabled
    always_comb begin
        nxt   = ch;
        found = 1'b0;
        for (int i = 1; i <= M; i++) begin
            if (!found && en[SW'((int'(ch) + i) % M)]) begin
                nxt   = SW'((int'(ch) + i) % M);
                found = 1'b1;
            end
        end
    end

    // slot counter and channel sequencing; the first edge after reset holds cnt at 0 so slot 0 is full length
    always_comb begin
        wrap   = mode && run && (cnt == CW'(DIV - 1));
        cnt_n  = '0;
        ch_n   = sel;
        tick_n = 1'b0;
        if (mode) begin
            ch_n = ch;
            if (run && !wrap)
                cnt_n = cnt + 1'b1;
            if (wrap && |en) begin
                ch_n   = nxt;
                tick_n = 1'b1;
            end
        end
    end

    // strobe and data derived from the next channel so y, ch and strobe stay consistent
    always_comb begin
        strobe_n = '0;
        y_n      = '0;
        for (int k = 0; k < M; k++) begin
            if (ch_n == SW'(k) && en[k]) begin
                strobe_n[k] = 1'b1;
                y_n         = d[k*N +: N];
            end
        end
`ifdef MUX_SCAN_BLANK_EN
        if (mode && cnt_n < CW'(BLANK)) begin
            strobe_n = '0;
            y_n      = '0;
        end
`endif
    end

`ifndef MUX_SCAN_BLANK_EN
    logic unused_blank;
    assign unused_blank = (BLANK > 0);
`endif

    // output and state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            y      <= '0;
            ch     <= '0;
            strobe <= '0;
            tick   <= 1'b0;
            cnt    <= '0;
            run    <= 1'b0;
        end else begin
            y      <= y_n;
            ch     <= ch_n;
            strobe <= strobe_n;
            tick   <= tick_n;
            cnt    <= cnt_n;
            run    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: directed self-checking bench for mux_scan with N=10, M=4, DIV=4
module tb_mux_scan;
`ifdef MUX_SCAN_BLANK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] d;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  en;
    logic [9:0]  y;
    logic [1:0]  ch;
    logic [3:0]  strobe;
    logic        tick;
    logic [9:0]  dv [4];
    int          checks = 0;
    int          errors = 0;

    assign d = {dv[3], dv[2], dv[1], dv[0]};

    mux_scan #(.N(10), .M(4), .DIV(4), .BLANK(1)) dut (
        .clk(clk), .reset(reset), .d(d), .mode(mode), .sel(sel), .en(en),
        .y(y), .ch(ch), .strobe(strobe), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        dv[0] = 10'h037; dv[1] = 10'h025; dv[2] = 10'h3FF; dv[3] = 10'h155;
        en = 4'b1111; mode = 1'b1; sel = 2'd0;
        do_reset();
        checks++; if (y !== 10'h0) begin errors++; $display("FAIL reset_y got %h exp 000", y); end
        checks++; if (ch !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d exp 0", ch); end
        checks++; if (strobe !== 4'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0000", strobe); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
        cyc(1);
        checks++; if (y !== (BLK ? 10'h0 : 10'h037)) begin errors++; $display("FAIL first_y got %h", y); end
        checks++; if (strobe !== (BLK ? 4'b0000 : 4'b0001)) begin errors++; $display("FAIL first_strobe got %b", strobe); end
        checks++; if (ch !== 2'd0) begin errors++; $display("FAIL first_ch got %0d exp 0", ch); end
    endtask

    task automatic test_manual();
        mode = 1'b0; sel = 2'd2;
        cyc(1);
        checks++; if (ch !== 2'd2) begin errors++; $display("FAIL man_ch got %0d exp 2", ch); end
        checks++; if (y !== 10'h3FF) begin errors++; $display("FAIL man_y got %h exp 3ff", y); end
        checks++; if (strobe !== 4'b0100) begin errors++; $display("FAIL man_strobe got %b exp 0100", strobe); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL man_tick got %b exp 0", tick); end
        sel = 2'd3;
        cyc(1);
        checks++; if (y !== 10'h155) begin errors++; $display("FAIL man3_y got %h exp 155", y); end
        checks++; if (strobe !== 4'b1000) begin errors++; $display("FAIL man3_strobe got %b exp 1000", strobe); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL man3_tick got %b exp 0", tick); end
        en = 4'b0111;
        cyc(1);
        checks++; if (strobe !== 4'b0000 || y !== 10'h0) begin errors++; $display("FAIL man_gate got %b/%h exp 0000/000", strobe, y); end
        en = 4'b1111;
    endtask

    task automatic test_scan();
        int ec, ecnt;
        logic [9:0] ey;
        logic [3:0] es;
        mode = 1'b1;
        do_reset();
        for (int j = 1; j <= 17; j++) begin
            cyc(1);
            ec   = ((j - 1) / 4) % 4;
            ecnt = (j - 1) % 4;
            es   = (BLK && ecnt == 0) ? 4'b0 : 4'b0001 << ec;
            ey   = (es == 4'b0) ? 10'h0 : dv[ec];
            checks++; if (ch !== 2'(ec)) begin errors++; $display("FAIL scan_ch j=%0d got %0d exp %0d", j, ch, ec); end
            checks++; if (tick !== (j > 1 && ecnt == 0)) begin errors++; $display("FAIL scan_tick j=%0d got %b", j, tick); end
            checks++; if (strobe !== es) begin errors++; $display("FAIL scan_strobe j=%0d got %b exp %b", j, strobe, es); end
            checks++; if (y !== ey) begin errors++; $display("FAIL scan_y j=%0d got %h exp %h", j, y, ey); end
            if (j == 6) begin
                dv[1] = 10'h2AA;
                #1;
                checks++; if (y !== 10'h025) begin errors++; $display("FAIL scan_latency got %h exp 025", y); end
            end
        end
        dv[1] = 10'h025;
    endtask

    task automatic test_en_mask();
        int ec, ecnt;
        mode = 1'b1; en = 4'b0101;
        do_reset();
        for (int j = 1; j <= 12; j++) begin
            cyc(1);
            ec   = (((j - 1) / 4) % 2) * 2;
            ecnt = (j - 1) % 4;
            checks++; if (ch !== 2'(ec)) begin errors++; $display("FAIL en_ch j=%0d got %0d exp %0d", j, ch, ec); end
            checks++; if (tick !== (j > 1 && ecnt == 0)) begin errors++; $display("FAIL en_tick j=%0d got %b", j, tick); end
        end
        en = 4'b0000;
        for (int j = 0; j < 6; j++) begin
            cyc(1);
            checks++; if (strobe !== 4'b0 || y !== 10'h0) begin errors++; $display("FAIL en0_out got %b/%h exp 0000/000", strobe, y); end
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL en0_tick got %b exp 0", tick); end
            checks++; if (ch !== 2'd0) begin errors++; $display("FAIL en0_ch got %0d exp 0", ch); end
        end
        en = 4'b1111;
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; en = 4'b1111;
        do_reset();
        cyc(11);
        checks++; if (ch !== 2'd2) begin errors++; $display("FAIL mid_pre_ch got %0d exp 2", ch); end
        reset = 1'b1;
        cyc(1);
        checks++; if (ch !== 2'd0 || y !== 10'h0 || strobe !== 4'b0 || tick !== 1'b0) begin
            errors++; $display("FAIL mid_reset got ch=%0d y=%h s=%b t=%b exp 0", ch, y, strobe, tick);
        end
        reset = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            cyc(1);
            checks++; if (ch !== 2'd0 || tick !== 1'b0) begin errors++; $display("FAIL mid_slot0 j=%0d got ch=%0d t=%b exp 0/0", j, ch, tick); end
        end
        cyc(1);
        checks++; if (ch !== 2'd1 || tick !== 1'b1) begin errors++; $display("FAIL mid_adv got ch=%0d t=%b exp 1/1", ch, tick); end
    endtask

    task automatic test_mode_switch();
        mode = 1'b0; sel = 2'd1;
        cyc(1);
        checks++; if (ch !== 2'd1) begin errors++; $display("FAIL sw_man_ch got %0d exp 1", ch); end
        mode = 1'b1;
        cyc(3);
        checks++; if (ch !== 2'd1 || tick !== 1'b0) begin errors++; $display("FAIL sw_hold got ch=%0d t=%b exp 1/0", ch, tick); end
        cyc(1);
        checks++; if (ch !== 2'd2 || tick !== 1'b1) begin errors++; $display("FAIL sw_adv got ch=%0d t=%b exp 2/1", ch, tick); end
        mode = 1'b0; sel = 2'd0;
        cyc(1);
        checks++; if (ch !== 2'd0 || tick !== 1'b0 || y !== 10'h037) begin errors++; $display("FAIL sw_back got ch=%0d t=%b y=%h exp 0/0/037", ch, tick, y); end
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; sel = 2'd0; en = 4'b0;
        dv[0] = '0; dv[1] = '0; dv[2] = '0; dv[3] = '0;
        test_reset();
        test_manual();
        test_scan();
        test_en_mask();
        test_reset_mid();
        test_mode_switch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
